baud_cfg_ctrl: RTL and testbench
================================

Name: baud_cfg_ctrl

Overview:
Configuration sequencer for the mini SPART baud rate generator. It accepts a 16-bit divisor request over a valid/ready handshake and performs the two-byte programming sequence on the generator's bus: low byte with sel_low, then high byte with sel_high. It then watches the generator's enable pulses to declare lock, and flags a timeout if pulses never appear or later stop. It sits between the host/config logic and the baud generator.

Parameters:
LOCK_PULSES, 4, number of brg_en pulses required in SETTLE before declaring lock (1..255)
TIMEOUT, 4096, watchdog limit in clk cycles without a brg_en pulse (1..65535; counter is 16 bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  divisor request valid
req_ready  out  1  controller can accept a request
req_div  in  16  requested divisor, sampled on handshake
brg_sel_low  out  1  write strobe, divisor low byte
brg_sel_high  out  1  write strobe, divisor high byte
brg_data  out  8  divisor byte to generator
brg_en  in  1  single-cycle enable pulse from generator
locked  out  1  generator programmed and pulsing
timeout_err  out  1  watchdog expired or zero divisor requested
cur_div  out  16  divisor from last accepted request

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; locked=0, timeout_err=0, cur_div=0, brg_sel_low=0, brg_sel_high=0, brg_data=8'h00; counters cleared. req_ready is forced to 0 while rst==0.
- States: IDLE, WR_LO, WR_HI, SETTLE, LOCKED, ERR. req_ready=1 only in IDLE, LOCKED, ERR.
- Handshake: a request is accepted at an edge where req_valid & req_ready. At that edge, req_div is latched into cur_div and the pulse and watchdog counters clear. Requests in any other state are not accepted, and req_valid must be held by the requester.
- After acceptance with req_div!=0, the sequence runs as follows:
  - Acceptance edge E0 -> WR_LO for cycle E0..E1: brg_sel_low=1, brg_data=cur_div[7:0].
  - WR_HI for E1..E2: brg_sel_high=1, brg_data=cur_div[15:8].
  - SETTLE from E2.
  - Each strobe is high for exactly one cycle, and the two strobes are never high together.
- Outside WR_LO/WR_HI, both strobes are 0 and brg_data=8'h00.
- req_div==0: the handshake completes but no bus writes occur. The next state is ERR with timeout_err=1; cur_div=0.
- SETTLE:
  - Each cycle with brg_en=1 increments the pulse count and clears the watchdog. Otherwise the watchdog increments.
  - When pulse count reaches LOCK_PULSES -> LOCKED; locked=1 from the next cycle.
  - When watchdog reaches TIMEOUT first -> ERR.
  - If the final pulse and the watchdog limit occur in the same cycle, the pulse wins (LOCKED).
- LOCKED: brg_en clears the watchdog. TIMEOUT cycles with no pulse -> ERR (loss of lock), locked drops to 0.
- ERR: timeout_err=1 and locked=0. Exit only by a new accepted request (timeout_err clears the cycle after acceptance) or by reset.
- New request while LOCKED: locked=0 from the cycle after acceptance, and the full sequence reruns.
- brg_en is ignored in IDLE, WR_LO, WR_HI, ERR.
- Reset mid-sequence: strobes drop at the reset edge and the generator may hold a partial divisor. The controller returns to IDLE with cur_div=0, and the host must reprogram.
- Counter widths: pulse count 8 bits, watchdog 16 bits. Neither wraps; both saturate at their limit compare.

Test Plan:
- Reset then request 16'h12C0 -> exactly one cycle sel_low=1/data=8'hC0, next cycle sel_high=1/data=8'h12, then both strobes 0, data 0; cur_div=16'h12C0.
- Use a bench generator model (or the real baud generator) pulsing every N cycles; LOCK_PULSES=4 -> locked rises the cycle after the 4th brg_en in SETTLE; req_ready=1 in LOCKED.
- TIMEOUT=64 with brg_en held 0 after programming -> timeout_err=1 and locked=0 at cycle 64 of SETTLE; a new request 16'h0010 clears timeout_err and reprograms bytes 8'h10 then 8'h00.
- While LOCKED, stop brg_en -> after 64 idle cycles locked=0, timeout_err=1. Separately, the 4th pulse coinciding with watchdog=64 -> LOCKED, not ERR.
- Request 16'h0000 -> no strobes, timeout_err=1 next cycle. Hold req_valid during WR_LO/WR_HI/SETTLE -> no second acceptance until LOCKED.
- Assert rst=0 during WR_HI -> sel_high=0 at reset edge, all outputs at reset values, req_ready=0 while rst=0 and 1 the first cycle after release.

Source files
------------

// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: configuration sequencer for the mini SPART baud generator.
// It accepts a 16-bit divisor over valid/ready and writes it to the generator
// as two bytes: first the low byte, then the high byte.
// It then counts brg_en pulses to declare lock.
// A watchdog raises timeout_err if pulses never start, or if they stop later.
module baud_cfg_ctrl #(
    parameter int LOCK_PULSES = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_div,
    output logic        brg_sel_low,
    output logic        brg_sel_high,
    output logic [7:0]  brg_data,
    input  logic        brg_en,
    output logic        locked,
    output logic        timeout_err,
    output logic [15:0] cur_div
);

    localparam logic [7:0]  LP_LOCK = 8'(LOCK_PULSES);
    localparam logic [15:0] LP_TO   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_LO  = 3'd1,
        ST_WR_HI  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_pulse_cnt;
    logic [7:0]  w_pulse_cnt_next;
    logic [15:0] r_wdog;
    logic [15:0] w_wdog_next;
    logic [15:0] r_cur_div;
    logic [15:0] w_cur_div_next;
    logic [7:0]  w_data_next;
    logic        r_sel_low;
    logic        r_sel_high;
    logic [7:0]  r_data;
    logic        r_locked;
    logic        r_err;
    logic        w_ready_state;
    logic        w_accept;
    logic [8:0]  w_pulse_inc;
    logic [16:0] w_wdog_inc;

    assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_LOCKED) || (r_state == ST_ERR);
    assign req_ready     = w_ready_state & rst;
    assign w_accept      = req_valid & req_ready;
    assign w_pulse_inc   = {1'b0, r_pulse_cnt} + 9'd1;
    assign w_wdog_inc    = {1'b0, r_wdog} + 17'd1;

    assign brg_sel_low  = r_sel_low;
    assign brg_sel_high = r_sel_high;
    assign brg_data     = r_data;
    assign locked       = r_locked;
    assign timeout_err  = r_err;
    assign cur_div      = r_cur_div;

    // Next-state, counter and divisor-latch logic; a pulse beats a same-cycle watchdog expiry.
    always_comb begin
        w_next_state     = r_state;
        w_pulse_cnt_next = r_pulse_cnt;
        w_wdog_next      = r_wdog;
        w_cur_div_next   = r_cur_div;
        if (w_accept) begin
            w_cur_div_next   = req_div;
            w_pulse_cnt_next = 8'd0;
            w_wdog_next      = 16'd0;
            if (req_div == 16'd0) begin
                w_next_state = ST_ERR;
            end else begin
                w_next_state = ST_WR_LO;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_IDLE;
                end
                ST_WR_LO: begin
                    w_next_state = ST_WR_HI;
                end
                ST_WR_HI: begin
                    w_next_state = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (brg_en) begin
                        w_wdog_next = 16'd0;
                        if (w_pulse_inc >= {1'b0, LP_LOCK}) begin
                            w_pulse_cnt_next = LP_LOCK;
                            w_next_state     = ST_LOCKED;
                        end else begin
                            w_pulse_cnt_next = w_pulse_inc[7:0];
                        end
                    end else if (w_wdog_inc >= {1'b0, LP_TO}) begin
                        w_wdog_next  = LP_TO;
                        w_next_state = ST_ERR;
                    end else begin
                        w_wdog_next = w_wdog_inc[15:0];
                    end
                end
                ST_LOCKED: begin
                    if (brg_en) begin
                        w_wdog_next = 16'd0;
                    end else if (w_wdog_inc >= {1'b0, LP_TO}) begin
                        w_wdog_next  = LP_TO;
                        w_next_state = ST_ERR;
                    end else begin
                        w_wdog_next = w_wdog_inc[15:0];
                    end
                end
                ST_ERR: begin
                    w_next_state = ST_ERR;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Byte presented to the generator in the cycle that follows.
    always_comb begin
        w_data_next = 8'h00;
        case (w_next_state)
            ST_WR_LO: w_data_next = w_cur_div_next[7:0];
            ST_WR_HI: w_data_next = w_cur_div_next[15:8];
            default:  w_data_next = 8'h00;
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pulse_cnt <= 8'd0;
            r_wdog      <= 16'd0;
            r_cur_div   <= 16'd0;
            r_sel_low   <= 1'b0;
            r_sel_high  <= 1'b0;
            r_data      <= 8'h00;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_wdog      <= w_wdog_next;
            r_cur_div   <= w_cur_div_next;
            r_sel_low   <= (w_next_state == ST_WR_LO);
            r_sel_high  <= (w_next_state == ST_WR_HI);
            r_data      <= w_data_next;
            r_locked    <= (w_next_state == ST_LOCKED);
            r_err       <= (w_next_state == ST_ERR);
        end
    end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Directed self-checking bench for baud_cfg_ctrl (LOCK_PULSES=4, TIMEOUT=64).
module tb_baud_cfg_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_div;
    logic        brg_sel_low;
    logic        brg_sel_high;
    logic [7:0]  brg_data;
    logic        brg_en;
    logic        locked;
    logic        timeout_err;
    logic [15:0] cur_div;

    int errors = 0;
    int checks = 0;

    baud_cfg_ctrl #(.LOCK_PULSES(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_div(req_div), .brg_sel_low(brg_sel_low), .brg_sel_high(brg_sel_high),
        .brg_data(brg_data), .brg_en(brg_en), .locked(locked),
        .timeout_err(timeout_err), .cur_div(cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept div and check the two-byte write sequence; ends in SETTLE.
    task automatic program_div(input logic [15:0] div);
        req_valid = 1'b1; req_div = div;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL prog_ready: got %b exp 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if ({brg_sel_low, brg_sel_high, brg_data} !== {1'b1, 1'b0, div[7:0]}) begin errors++; $display("FAIL prog_lo: got lo=%b hi=%b d=%h exp lo=1 hi=0 d=%h", brg_sel_low, brg_sel_high, brg_data, div[7:0]); end
        checks++; if (cur_div !== div) begin errors++; $display("FAIL prog_cur_div: got %h exp %h", cur_div, div); end
        checks++; if ({req_ready, locked, timeout_err} !== 3'b000) begin errors++; $display("FAIL prog_flags_lo: got rdy/lk/err=%b exp 000", {req_ready, locked, timeout_err}); end
        tick();
        checks++; if ({brg_sel_low, brg_sel_high, brg_data} !== {1'b0, 1'b1, div[15:8]}) begin errors++; $display("FAIL prog_hi: got lo=%b hi=%b d=%h exp lo=0 hi=1 d=%h", brg_sel_low, brg_sel_high, brg_data, div[15:8]); end
        tick();
        checks++; if ({brg_sel_low, brg_sel_high, brg_data} !== 10'd0) begin errors++; $display("FAIL prog_idle_bus: got lo=%b hi=%b d=%h exp 0 0 00", brg_sel_low, brg_sel_high, brg_data); end
    endtask

    // Four pulses every third cycle from SETTLE; lock appears after the 4th.
    task automatic lock_with_pulses();
        for (int p = 1; p <= 4; p++) begin
            brg_en = 1'b0; tick(); tick();
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: pulse %0d got %b exp 0", p, locked); end
            brg_en = 1'b1; tick();
        end
        brg_en = 1'b0;
        checks++; if ({locked, req_ready, timeout_err} !== 3'b110) begin errors++; $display("FAIL lock_rise: got lk/rdy/err=%b exp 110", {locked, req_ready, timeout_err}); end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_div = 16'h0000; brg_en = 1'b0;
        tick(); tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", req_ready); end
        checks++; if ({brg_sel_low, brg_sel_high, brg_data, locked, timeout_err, cur_div} !== 28'd0) begin errors++; $display("FAIL reset_outs: got lo=%b hi=%b d=%h lk=%b err=%b div=%h exp all 0", brg_sel_low, brg_sel_high, brg_data, locked, timeout_err, cur_div); end
        rst = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_program_and_lock();
        program_div(16'h12C0);
        lock_with_pulses();
    endtask

    task automatic test_loss_of_lock();
        for (int i = 0; i < 63; i++) tick();
        checks++; if ({locked, timeout_err} !== 2'b10) begin errors++; $display("FAIL lol_63: got lk/err=%b exp 10", {locked, timeout_err}); end
        tick();
        checks++; if ({locked, timeout_err} !== 2'b01) begin errors++; $display("FAIL lol_64: got lk/err=%b exp 01", {locked, timeout_err}); end
    endtask

    task automatic test_settle_timeout();
        program_div(16'h0010);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_cleared: got %b exp 0", timeout_err); end
        brg_en = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        checks++; if ({locked, timeout_err} !== 2'b00) begin errors++; $display("FAIL to_63: got lk/err=%b exp 00", {locked, timeout_err}); end
        tick();
        checks++; if ({locked, timeout_err, req_ready} !== 3'b011) begin errors++; $display("FAIL to_64: got lk/err/rdy=%b exp 011", {locked, timeout_err, req_ready}); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", timeout_err); end
    endtask

    task automatic test_pulse_wins_tie();
        program_div(16'h0203);
        brg_en = 1'b1; tick(); tick(); tick();
        brg_en = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        checks++; if ({locked, timeout_err} !== 2'b00) begin errors++; $display("FAIL tie_pre: got lk/err=%b exp 00", {locked, timeout_err}); end
        brg_en = 1'b1; tick(); brg_en = 1'b0;
        checks++; if ({locked, timeout_err} !== 2'b10) begin errors++; $display("FAIL tie_lock: got lk/err=%b exp 10", {locked, timeout_err}); end
    endtask

    task automatic test_zero_div();
        req_valid = 1'b1; req_div = 16'h0000;
        tick();
        req_valid = 1'b0;
        checks++; if ({brg_sel_low, brg_sel_high, brg_data} !== 10'd0) begin errors++; $display("FAIL zero_bus: got lo=%b hi=%b d=%h exp 0 0 00", brg_sel_low, brg_sel_high, brg_data); end
        checks++; if ({timeout_err, locked, cur_div} !== 18'h20000) begin errors++; $display("FAIL zero_flags: got err=%b lk=%b div=%h exp 1 0 0000", timeout_err, locked, cur_div); end
        tick();
        checks++; if ({brg_sel_low, brg_sel_high, timeout_err} !== 3'b001) begin errors++; $display("FAIL zero_after: got lo/hi/err=%b exp 001", {brg_sel_low, brg_sel_high, timeout_err}); end
    endtask

    task automatic test_back_to_back();
        int extra_lo;
        extra_lo = 0;
        req_valid = 1'b1; req_div = 16'hABCD;
        tick();
        checks++; if ({brg_sel_low, brg_data} !== {1'b1, 8'hCD}) begin errors++; $display("FAIL b2b_lo: got lo=%b d=%h exp 1 cd", brg_sel_low, brg_data); end
        tick();
        checks++; if ({brg_sel_high, brg_data} !== {1'b1, 8'hAB}) begin errors++; $display("FAIL b2b_hi: got hi=%b d=%h exp 1 ab", brg_sel_high, brg_data); end
        tick();
        for (int p = 1; p <= 4; p++) begin
            brg_en = 1'b0; tick();
            if (brg_sel_low === 1'b1) extra_lo++;
            brg_en = 1'b1; tick();
            if (p < 4 && brg_sel_low === 1'b1) extra_lo++;
        end
        brg_en = 1'b0;
        checks++; if (extra_lo !== 0) begin errors++; $display("FAIL b2b_no_reaccept: got %0d strobes exp 0", extra_lo); end
        checks++; if ({locked, req_ready} !== 2'b11) begin errors++; $display("FAIL b2b_locked: got lk/rdy=%b exp 11", {locked, req_ready}); end
        req_div = 16'h5A3C;
        tick();
        req_valid = 1'b0;
        checks++; if ({locked, brg_sel_low, brg_data, cur_div} !== {2'b01, 8'h3C, 16'h5A3C}) begin errors++; $display("FAIL b2b_rerun: got lk=%b lo=%b d=%h div=%h exp 0 1 3c 5a3c", locked, brg_sel_low, brg_data, cur_div); end
    endtask

    task automatic test_reset_mid_sequence();
        tick();
        checks++; if (brg_sel_high !== 1'b1) begin errors++; $display("FAIL rst_pre_hi: got %b exp 1", brg_sel_high); end
        rst = 1'b0;
        tick();
        checks++; if ({brg_sel_low, brg_sel_high, brg_data, locked, timeout_err, cur_div} !== 28'd0) begin errors++; $display("FAIL rst_mid_outs: got lo=%b hi=%b d=%h lk=%b err=%b div=%h exp all 0", brg_sel_low, brg_sel_high, brg_data, locked, timeout_err, cur_div); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b exp 0", req_ready); end
        rst = 1'b1;
        tick();
        checks++; if ({req_ready, brg_sel_low, brg_sel_high} !== 3'b100) begin errors++; $display("FAIL rst_post: got rdy/lo/hi=%b exp 100", {req_ready, brg_sel_low, brg_sel_high}); end
    endtask

    initial begin
        test_reset();
        test_program_and_lock();
        test_loss_of_lock();
        test_settle_timeout();
        test_pulse_wins_tie();
        test_zero_div();
        test_back_to_back();
        test_reset_mid_sequence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
